// File: rtl/asg_sweep_sequencer.sv
// Stepped-frequency sweep sequencer for one ASG channel: table fetch -> DDS load ->
// settle -> measure -> write magnitude/phase results, repeated per point and per repetition.
module asg_sweep_sequencer #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAG_W    = 14,
  parameter int unsigned SETTLE_W = 16,
  parameter int unsigned TMO_W    = 24
) (
  input  logic                dac_clk_i,
  input  logic                dac_rst_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [ADDR_W:0]     npts_i,
  input  logic [7:0]          nrep_i,
  input  logic [SETTLE_W-1:0] settle_i,
  input  logic [TMO_W-1:0]    timeout_i,
  output logic [ADDR_W-1:0]   tbl_addr_o,
  input  logic [DATA_W-1:0]   tbl_data_i,
  output logic [DATA_W-1:0]   phase_inc_o,
  output logic                phase_inc_vld_o,
  output logic                meas_start_o,
  input  logic                meas_done_i,
  input  logic [MAG_W-1:0]    meas_mod_i,
  input  logic [MAG_W-1:0]    meas_pha_i,
  output logic                res_we_o,
  output logic [ADDR_W:0]     res_addr_o,
  output logic [MAG_W-1:0]    res_data_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                timeout_err_o,
  output logic [ADDR_W-1:0]   point_o,
  output logic [7:0]          rep_o
);

  localparam int unsigned PW = ADDR_W + 1;
  localparam logic [ADDR_W:0] NPTS_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SETTLE, S_MEAS, S_WR_MOD, S_WR_PHA, S_NEXT, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     npts_q, npts_d;
  logic [7:0]          nrep_q, nrep_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [TMO_W-1:0]    timeout_q, timeout_d;
  logic [ADDR_W-1:0]   point_q, point_d;
  logic [7:0]          rep_q, rep_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [MAG_W-1:0]    mod_q, mod_d, pha_q, pha_d;
  logic [ADDR_W-1:0]   tbl_addr_q, tbl_addr_d;
  logic [DATA_W-1:0]   phase_inc_q, phase_inc_d;
  logic                phase_vld_q, phase_vld_d;
  logic                meas_start_q, meas_start_d;
  logic                res_we_q, res_we_d;
  logic [ADDR_W:0]     res_addr_q, res_addr_d;
  logic [MAG_W-1:0]    res_data_q, res_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [8:0]          nrep_eff;

  assign nrep_eff = (nrep_q == 8'd0) ? 9'd1 : {1'b0, nrep_q};

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    npts_d       = npts_q;
    nrep_d       = nrep_q;
    settle_d     = settle_q;
    timeout_d    = timeout_q;
    point_d      = point_q;
    rep_d        = rep_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    mod_d        = mod_q;
    pha_d        = pha_q;
    phase_inc_d  = phase_inc_q;
    phase_vld_d  = 1'b0;
    meas_start_d = 1'b0;
    err_d        = err_q;

    if (abort_i && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i && !abort_i && npts_i != '0 && npts_i <= NPTS_MAX) begin
            state_d   = S_FETCH;
            npts_d    = npts_i;
            nrep_d    = nrep_i;
            settle_d  = settle_i;
            timeout_d = timeout_i;
            point_d   = '0;
            rep_d     = '0;
            err_d     = 1'b0;
          end
        end
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          state_d     = S_SETTLE;
          phase_inc_d = tbl_data_i;
          phase_vld_d = 1'b1;
          cnt_d       = settle_q;
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            state_d      = S_MEAS;
            tmo_d        = '0;
            meas_start_d = 1'b1;
          end else begin
            cnt_d = cnt_q - SETTLE_W'(1);
          end
        end
        S_MEAS: begin
          tmo_d = tmo_q + TMO_W'(1);
          // err is raised the cycle the counter reads timeout; the exit follows it
          if (timeout_q != '0 && tmo_q == timeout_q) begin
            state_d = S_IDLE;
          end else if (meas_done_i && !meas_start_q) begin
            state_d = S_WR_MOD;
            mod_d   = meas_mod_i;
            pha_d   = meas_pha_i;
          end else if (timeout_q != '0 && tmo_q + TMO_W'(1) == timeout_q) begin
            err_d = 1'b1;
          end
        end
        S_WR_MOD: state_d = S_WR_PHA;
        S_WR_PHA: state_d = S_NEXT;
        S_NEXT: begin
          if ({1'b0, point_q} + PW'(1) < npts_q) begin
            point_d = point_q + ADDR_W'(1);
            state_d = S_FETCH;
          end else begin
            rep_d = rep_q + 8'd1;
            if ({1'b0, rep_q} + 9'd1 < nrep_eff) begin
              point_d = '0;
              state_d = S_FETCH;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    tbl_addr_d = (state_d == S_FETCH) ? point_d : tbl_addr_q;
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    res_we_d   = (state_d == S_WR_MOD) || (state_d == S_WR_PHA);
    res_addr_d = res_addr_q;
    res_data_d = res_data_q;
    if (state_d == S_WR_MOD) begin
      res_addr_d = {1'b0, point_q};
      res_data_d = mod_d;
    end else if (state_d == S_WR_PHA) begin
      res_addr_d = {1'b1, point_q};
      res_data_d = pha_d;
    end
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state_q      <= S_IDLE;
      npts_q       <= '0;
      nrep_q       <= '0;
      settle_q     <= '0;
      timeout_q    <= '0;
      point_q      <= '0;
      rep_q        <= '0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      mod_q        <= '0;
      pha_q        <= '0;
      tbl_addr_q   <= '0;
      phase_inc_q  <= '0;
      phase_vld_q  <= 1'b0;
      meas_start_q <= 1'b0;
      res_we_q     <= 1'b0;
      res_addr_q   <= '0;
      res_data_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      npts_q       <= npts_d;
      nrep_q       <= nrep_d;
      settle_q     <= settle_d;
      timeout_q    <= timeout_d;
      point_q      <= point_d;
      rep_q        <= rep_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      mod_q        <= mod_d;
      pha_q        <= pha_d;
      tbl_addr_q   <= tbl_addr_d;
      phase_inc_q  <= phase_inc_d;
      phase_vld_q  <= phase_vld_d;
      meas_start_q <= meas_start_d;
      res_we_q     <= res_we_d;
      res_addr_q   <= res_addr_d;
      res_data_q   <= res_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign tbl_addr_o      = tbl_addr_q;
  assign phase_inc_o     = phase_inc_q;
  assign phase_inc_vld_o = phase_vld_q;
  assign meas_start_o    = meas_start_q;
  assign res_we_o        = res_we_q;
  assign res_addr_o      = res_addr_q;
  assign res_data_o      = res_data_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign timeout_err_o   = err_q;
  assign point_o         = point_q;
  assign rep_o           = rep_q;

endmodule

// File: tb/tb_asg_sweep_sequencer.sv
// Scoreboard bench for asg_sweep_sequencer: expected DDS loads and result writes are
// queued by each directed test and consumed by an independent output monitor.
module tb_asg_sweep_sequencer;

  localparam int unsigned ADDR_W = 8, DATA_W = 32, MAG_W = 14, SETTLE_W = 16, TMO_W = 24;

  logic                dac_clk_i, dac_rst_i, start_i, abort_i;
  logic [ADDR_W:0]     npts_i;
  logic [7:0]          nrep_i;
  logic [SETTLE_W-1:0] settle_i;
  logic [TMO_W-1:0]    timeout_i;
  logic [ADDR_W-1:0]   tbl_addr_o;
  logic [DATA_W-1:0]   tbl_data_i, phase_inc_o;
  logic                phase_inc_vld_o, meas_start_o, meas_done_i;
  logic [MAG_W-1:0]    meas_mod_i, meas_pha_i, res_data_o;
  logic                res_we_o, busy_o, done_o, timeout_err_o;
  logic [ADDR_W:0]     res_addr_o;
  logic [ADDR_W-1:0]   point_o;
  logic [7:0]          rep_o;

  asg_sweep_sequencer dut (
    .dac_clk_i(dac_clk_i), .dac_rst_i(dac_rst_i), .start_i(start_i), .abort_i(abort_i),
    .npts_i(npts_i), .nrep_i(nrep_i), .settle_i(settle_i), .timeout_i(timeout_i),
    .tbl_addr_o(tbl_addr_o), .tbl_data_i(tbl_data_i), .phase_inc_o(phase_inc_o),
    .phase_inc_vld_o(phase_inc_vld_o), .meas_start_o(meas_start_o), .meas_done_i(meas_done_i),
    .meas_mod_i(meas_mod_i), .meas_pha_i(meas_pha_i), .res_we_o(res_we_o),
    .res_addr_o(res_addr_o), .res_data_o(res_data_o), .busy_o(busy_o), .done_o(done_o),
    .timeout_err_o(timeout_err_o), .point_o(point_o), .rep_o(rep_o)
  );

  typedef struct packed {
    logic [ADDR_W:0]  addr;
    logic [MAG_W-1:0] data;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] pinc_q[$];
  int errors = 0, checks = 0;
  int cyc = 0;
  int done_cnt = 0, last_vld_cyc = 0, ms_cyc = -1, err_rise_cyc = -1, busy_fall_cyc = -1;
  int exp_gap = 0, exp_rep = 0, core_lat = 1, core_mode = 0;
  bit chk_gap = 0, abort_seen = 0, err_prev = 0, busy_prev = 0;

  initial dac_clk_i = 1'b0;
  always #5 dac_clk_i = ~dac_clk_i;
  always @(posedge dac_clk_i) cyc <= cyc + 1;

  // Synchronous frequency table: entry i holds 0x1000*(i+1)
  always @(posedge dac_clk_i) tbl_data_i <= 32'h1000 * ({24'd0, tbl_addr_o} + 32'd1);

  function automatic logic [MAG_W-1:0] f_mod(input int p);
    return 14'(32'h100 + p);
  endfunction
  function automatic logic [MAG_W-1:0] f_pha(input int p);
    return 14'(32'h2000 + p);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Measurement core model: mode 1 answers, mode 2 answers together with abort_i
  initial begin
    int p;
    meas_done_i = 1'b0; abort_i = 1'b0; meas_mod_i = '0; meas_pha_i = '0;
    forever begin
      @(negedge dac_clk_i);
      if (meas_start_o && core_mode != 0) begin
        p = int'(point_o);
        repeat (core_lat) @(negedge dac_clk_i);
        meas_done_i = 1'b1;
        meas_mod_i  = f_mod(p);
        meas_pha_i  = f_pha(p);
        if (core_mode == 2) begin
          abort_i    = 1'b1;
          abort_seen = 1'b1;
        end
        @(negedge dac_clk_i);
        meas_done_i = 1'b0;
        abort_i     = 1'b0;
      end
    end
  end

  // Output monitor / scoreboard
  always @(negedge dac_clk_i) begin
    wr_t w;
    logic [31:0] pv;
    if (!dac_rst_i) begin
      if (res_we_o) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h", res_addr_o, res_data_o);
        end else begin
          w = wr_q.pop_front();
          chk("wr_addr", 64'(res_addr_o), 64'(w.addr));
          chk("wr_data", 64'(res_data_o), 64'(w.data));
        end
      end
      if (phase_inc_vld_o) begin
        last_vld_cyc = cyc;
        if (pinc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_phase_inc: 0x%0h", phase_inc_o);
        end else begin
          pv = pinc_q.pop_front();
          chk("phase_inc", 64'(phase_inc_o), 64'(pv));
        end
      end
      if (meas_start_o) begin
        ms_cyc = cyc;
        if (chk_gap) chk("settle_len", 64'(cyc - last_vld_cyc), 64'(exp_gap));
      end
      if (done_o) begin
        done_cnt++;
        chk("rep_at_done", 64'(rep_o), 64'(exp_rep));
      end
      if (timeout_err_o && !err_prev) err_rise_cyc = cyc;
      if (!busy_o && busy_prev) busy_fall_cyc = cyc;
    end
    err_prev  = timeout_err_o;
    busy_prev = busy_o;
  end

  task automatic push_exp(input int npts, input int nrep);
    int reps;
    reps = (nrep == 0) ? 1 : nrep;
    for (int r = 0; r < reps; r++)
      for (int p = 0; p < npts; p++) begin
        pinc_q.push_back(32'h1000 * 32'(p + 1));
        wr_q.push_back({1'b0, 8'(p), f_mod(p)});
        wr_q.push_back({1'b1, 8'(p), f_pha(p)});
      end
  endtask

  task automatic run(input int npts, input int nrep, input int settle, input int tmo);
    @(negedge dac_clk_i);
    npts_i = 9'(npts); nrep_i = 8'(nrep); settle_i = 16'(settle); timeout_i = 24'(tmo);
    start_i = 1'b1;
    @(negedge dac_clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge dac_clk_i);
      n++;
    end
    repeat (10) @(posedge dac_clk_i);
    chk({name, "_done_once"}, 64'(done_cnt), 64'(d0 + 1));
    chk({name, "_wr_left"}, 64'(wr_q.size()), 64'd0);
    chk({name, "_pinc_left"}, 64'(pinc_q.size()), 64'd0);
    chk({name, "_busy_end"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    int n, d0;
    dac_rst_i = 1'b1; start_i = 1'b0;
    npts_i = '0; nrep_i = '0; settle_i = '0; timeout_i = '0;
    repeat (3) @(posedge dac_clk_i);
    @(negedge dac_clk_i);
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_done", 64'(done_o), 0);
    chk("rst_err", 64'(timeout_err_o), 0);
    chk("rst_phase", 64'(phase_inc_o), 0);
    chk("rst_strobes", 64'({phase_inc_vld_o, meas_start_o, res_we_o}), 0);
    chk("rst_addr", 64'({tbl_addr_o, res_addr_o, res_data_o}), 0);
    chk("rst_point_rep", 64'({point_o, rep_o}), 0);
    dac_rst_i = 1'b0;

    // Basic 4-point sweep, 10-cycle core latency, settle 3 -> SETTLE spans 4 cycles
    core_mode = 1; core_lat = 10; chk_gap = 1; exp_gap = 4; exp_rep = 1;
    push_exp(4, 1);
    run(4, 1, 3, 0);
    wait_done("t1", 2000);

    // Full table, nrep=0 treated as one repetition
    core_lat = 2; exp_gap = 1; exp_rep = 1;
    push_exp(256, 0);
    run(256, 0, 0, 0);
    wait_done("t2", 10000);
    chk("t2_point", 64'(point_o), 64'd255);
    chk("t2_rep", 64'(rep_o), 64'd1);

    // Two points, three repetitions
    core_lat = 4; exp_gap = 2; exp_rep = 3;
    push_exp(2, 3);
    run(2, 3, 1, 0);
    wait_done("t3", 2000);

    // Illegal point counts are ignored; state stays at last sweep's final point
    for (int k = 0; k < 2; k++) begin
      run((k == 0) ? 0 : 257, 1, 0, 0);
      repeat (5) @(negedge dac_clk_i);
      chk("ign_busy", 64'(busy_o), 0);
      chk("ign_tbl_addr", 64'(tbl_addr_o), 64'd1);
      chk("ign_point", 64'(point_o), 64'd1);
    end

    // Timeout with a silent core
    core_mode = 0; exp_gap = 3;
    pinc_q.push_back(32'h1000);
    d0 = done_cnt; err_rise_cyc = -1; busy_fall_cyc = -1; ms_cyc = -1;
    run(1, 1, 2, 50);
    n = 0;
    while (busy_fall_cyc < 0 && n < 500) begin
      @(posedge dac_clk_i);
      n++;
    end
    @(negedge dac_clk_i);
    chk("tmo_err_set", 64'(timeout_err_o), 64'd1);
    chk("tmo_err_cycle", 64'(err_rise_cyc - ms_cyc), 64'd50);
    chk("tmo_busy_fall", 64'(busy_fall_cyc - err_rise_cyc), 64'd1);
    chk("tmo_no_done", 64'(done_cnt), 64'(d0));
    chk("tmo_no_write", 64'(wr_q.size() + pinc_q.size()), 64'd0);
    core_mode = 1; core_lat = 3; exp_gap = 1; exp_rep = 1;
    push_exp(1, 1);
    run(1, 1, 0, 50);
    chk("tmo_cleared", 64'(timeout_err_o), 64'd0);
    wait_done("t4b", 1000);

    // Abort coincident with meas_done
    core_mode = 2; core_lat = 3; exp_gap = 2;
    pinc_q.push_back(32'h1000);
    d0 = done_cnt; abort_seen = 0;
    run(3, 1, 1, 0);
    n = 0;
    while (!abort_seen && n < 200) begin
      @(posedge dac_clk_i);
      n++;
    end
    @(negedge dac_clk_i);
    chk("abort_busy", 64'(busy_o), 64'd0);
    repeat (20) @(negedge dac_clk_i);
    chk("abort_no_done", 64'(done_cnt), 64'(d0));
    chk("abort_no_write", 64'(wr_q.size() + pinc_q.size()), 64'd0);
    chk("abort_phase_hold", 64'(phase_inc_o), 64'h1000);
    chk("abort_point_hold", 64'(point_o), 64'd0);

    // Start while busy is ignored
    core_mode = 1; core_lat = 3; exp_gap = 21; exp_rep = 1;
    push_exp(2, 1);
    run(2, 1, 20, 0);
    repeat (6) @(negedge dac_clk_i);
    run(4, 2, 0, 0);
    chk("busy_start_busy", 64'(busy_o), 64'd1);
    chk("busy_start_point", 64'(point_o), 64'd0);
    wait_done("t6", 2000);
    chk("phase_hold_end", 64'(phase_inc_o), 64'h2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
